// File: rtl/apb_dual_master_arbiter_if.sv
// APB bus between the dual-requester arbiter (master) and the shared APB memory (slave).
interface apb_dual_master_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] Paddr;
    logic              Pselx;
    logic              Penable;
    logic              Pwrite;
    logic [DATA_W-1:0] Pwdata;
    logic [DATA_W-1:0] Prdata;
    logic              Pready;
    logic              Pslverr;

    modport master (
        output Paddr, Pselx, Penable, Pwrite, Pwdata,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        input  Paddr, Pselx, Penable, Pwrite, Pwdata,
        output Prdata, Pready, Pslverr
    );
endinterface

// File: rtl/apb_dual_master_arbiter.sv
// Round-robin arbiter sharing one APB slave between two requesters.
// Optional ACCESS-phase wait-state timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_dual_master_arbiter #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  Pclk,
    input  logic                  Prst,
    input  logic [1:0]            req,
    input  logic [1:0]            wr,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic [1:0]            done,
    output logic [DATA_W-1:0]     rdata,
    output logic                  err,
    output logic                  grant_id,
    output logic                  busy,
    apb_dual_master_arbiter_if.master apb
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              state, state_nxt;
    logic                last_grant, last_grant_nxt;
    logic                grant_nxt, busy_nxt, err_nxt;
    logic [1:0]          done_nxt, elig;
    logic [DATA_W-1:0]   rdata_nxt;
    logic                sel, sel_nxt, en, en_nxt, pwrite, pwrite_nxt;
    logic [ADDR_W-1:0]   paddr, paddr_nxt;
    logic [DATA_W-1:0]   pwdata, pwdata_nxt;
    logic                win;
    logic                timeout;

    // A requester whose done pulse is showing cannot win in the same cycle.
    assign elig = req & ~done;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge Pclk or posedge Prst) begin
        if (Prst) begin
            cnt <= '0;
        end else if (state == SETUP) begin
            cnt <= '0;
        end else if (state == ACCESS && !apb.Pready) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign timeout = (state == ACCESS) && !apb.Pready && (cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        grant_nxt      = grant_id;
        busy_nxt       = busy;
        done_nxt       = 2'b00;
        rdata_nxt      = '0;
        err_nxt        = 1'b0;
        sel_nxt        = sel;
        en_nxt         = en;
        pwrite_nxt     = pwrite;
        paddr_nxt      = paddr;
        pwdata_nxt     = pwdata;
        win            = (elig == 2'b11) ? ~last_grant : elig[1];

        unique case (state)
            IDLE: begin
                if (|elig) begin
                    state_nxt      = SETUP;
                    last_grant_nxt = win;
                    grant_nxt      = win;
                    busy_nxt       = 1'b1;
                    sel_nxt        = 1'b1;
                    en_nxt         = 1'b0;
                    pwrite_nxt     = wr[win];
                    paddr_nxt      = win ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
                    if (wr[win]) begin
                        pwdata_nxt = win ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
                    end else begin
                        pwdata_nxt = '0;
                    end
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
                en_nxt    = 1'b1;
            end
            ACCESS: begin
                if (apb.Pready) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    sel_nxt   = 1'b0;
                    en_nxt    = 1'b0;
                    done_nxt  = grant_id ? 2'b10 : 2'b01;
                    rdata_nxt = pwrite ? '0 : apb.Prdata;
                    err_nxt   = apb.Pslverr;
                end else if (timeout) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    sel_nxt   = 1'b0;
                    en_nxt    = 1'b0;
                    done_nxt  = grant_id ? 2'b10 : 2'b01;
                    err_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Pclk or posedge Prst) begin
        if (Prst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            busy       <= 1'b0;
            done       <= 2'b00;
            rdata      <= '0;
            err        <= 1'b0;
            sel        <= 1'b0;
            en         <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            grant_id   <= grant_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            rdata      <= rdata_nxt;
            err        <= err_nxt;
            sel        <= sel_nxt;
            en         <= en_nxt;
            pwrite     <= pwrite_nxt;
            paddr      <= paddr_nxt;
            pwdata     <= pwdata_nxt;
        end
    end

    assign apb.Pselx   = sel;
    assign apb.Penable = en;
    assign apb.Pwrite  = pwrite;
    assign apb.Paddr   = paddr;
    assign apb.Pwdata  = pwdata;

endmodule

// File: tb/tb_apb_dual_master_arbiter.sv
// Directed bench for apb_dual_master_arbiter with a small APB memory model.
module tb_apb_dual_master_arbiter;

    logic        Pclk = 1'b0;
    logic        Prst;
    logic [1:0]  req, wr, done;
    logic [9:0]  addr;
    logic [63:0] wdata;
    logic [31:0] rdata;
    logic        err, grant_id, busy;
    int          tests = 0;
    int          fails = 0;

    logic [31:0] mem [32] = '{default: 32'h0};

    apb_dual_master_arbiter_if #(.ADDR_W(5), .DATA_W(32)) apb();

    apb_dual_master_arbiter #(.ADDR_W(5), .DATA_W(32), .TIMEOUT(16)) dut (
        .Pclk     (Pclk),
        .Prst     (Prst),
        .req      (req),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .done     (done),
        .rdata    (rdata),
        .err      (err),
        .grant_id (grant_id),
        .busy     (busy),
        .apb      (apb)
    );

    always #5 Pclk = ~Pclk;

    assign apb.Prdata = mem[apb.Paddr];

    always @(posedge Pclk) begin
        if (apb.Pselx && apb.Penable && apb.Pready && apb.Pwrite)
            mem[apb.Paddr] <= apb.Pwdata;
    end

    task automatic tick();
        @(posedge Pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        Prst = 1'b1; req = 2'b00; wr = 2'b00; addr = '0; wdata = '0;
        apb.Pready = 1'b1; apb.Pslverr = 1'b0;
        tick(); tick();
        check("rst_done", done, 0);
        check("rst_pselx", apb.Pselx, 0);
        check("rst_penable", apb.Penable, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_rdata", rdata, 0);
        Prst = 1'b0;
        tick();

        // single write from requester 0
        req = 2'b01; wr = 2'b01; addr[4:0] = 5'd5; wdata[31:0] = 32'hDEADBEEF;
        tick();
        check("w_pselx", apb.Pselx, 1);
        check("w_penable0", apb.Penable, 0);
        check("w_paddr", apb.Paddr, 5);
        check("w_pwrite", apb.Pwrite, 1);
        check("w_pwdata", apb.Pwdata, 32'hDEADBEEF);
        check("w_grant", grant_id, 0);
        check("w_busy", busy, 1);
        req = 2'b00; wr = 2'b00; addr = '0; wdata = '0;
        tick();
        check("w_penable1", apb.Penable, 1);
        check("w_done_early", done, 0);
        tick();
        check("w_done", done, 2'b01);
        check("w_err", err, 0);
        check("w_pselx_off", apb.Pselx, 0);
        check("w_busy_off", busy, 0);
        check("w_mem", mem[5], 32'hDEADBEEF);

        // read-back from requester 1
        req = 2'b10; wr = 2'b00; addr[9:5] = 5'd5; wdata[63:32] = 32'hFFFFFFFF;
        tick();
        check("r_grant", grant_id, 1);
        check("r_pwrite", apb.Pwrite, 0);
        check("r_pwdata", apb.Pwdata, 0);
        check("r_paddr", apb.Paddr, 5);
        req = 2'b00; addr = '0; wdata = '0;
        tick(); tick();
        check("r_done", done, 2'b10);
        check("r_rdata", rdata, 32'hDEADBEEF);
        tick();
        check("r_done_pulse", done, 0);

        // contention: both requesting, four transfers alternate
        req = 2'b11; wr = 2'b11; addr = {5'd2, 5'd1}; wdata = {32'h2222_2222, 32'h1111_1111};
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("c%0d_grant", k), grant_id, k % 2);
            check($sformatf("c%0d_setup", k), {apb.Pselx, apb.Penable}, 2'b10);
            tick();
            check($sformatf("c%0d_access", k), {apb.Pselx, apb.Penable}, 2'b11);
            tick();
            check($sformatf("c%0d_done", k), done, (k % 2) ? 2'b10 : 2'b01);
            if (k == 3) req = 2'b00;
            tick();
            check($sformatf("c%0d_pulse", k), done, 0);
        end
        check("c_busy_idle", busy, 0);
        check("c_mem1", mem[1], 32'h1111_1111);
        check("c_mem2", mem[2], 32'h2222_2222);

        // wait states then slave error on a read
        apb.Pready = 1'b0;
        req = 2'b01; wr = 2'b00; addr = {5'd0, 5'd5};
        tick();
        check("ws_setup", {apb.Pselx, apb.Penable}, 2'b10);
        req = 2'b00; addr = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("ws%0d_apb", i), {apb.Pselx, apb.Penable, apb.Pwrite, apb.Paddr}, {3'b110, 5'd5});
            check($sformatf("ws%0d_done", i), done, 0);
        end
        apb.Pready = 1'b1; apb.Pslverr = 1'b1;
        tick();
        apb.Pslverr = 1'b0;
        check("ws_done", done, 2'b01);
        check("ws_err", err, 1);
        check("ws_rdata", rdata, 32'hDEADBEEF);
        tick();
        check("ws_err_clear", {done, err}, 3'b000);

        // reset during ACCESS of a write to address 9
        apb.Pready = 1'b0;
        req = 2'b01; wr = 2'b01; addr = {5'd0, 5'd9}; wdata = {32'h0, 32'h1234_5678};
        tick();
        req = 2'b00; wr = 2'b00; addr = '0; wdata = '0;
        tick();
        check("ra_access", apb.Penable, 1);
        Prst = 1'b1;
        #1;
        check("ra_apb", {apb.Pselx, apb.Penable, apb.Pwrite, apb.Paddr, apb.Pwdata}, 0);
        check("ra_outs", {done, rdata, err, grant_id, busy}, 0);
        apb.Pready = 1'b1;
        tick();
        check("ra_no_done", done, 0);
        check("ra_mem9", mem[9], 0);
        Prst = 1'b0;
        req = 2'b11; wr = 2'b00; addr = {5'd1, 5'd2};
        tick();
        check("ra_grant0", grant_id, 0);
        check("ra_paddr", apb.Paddr, 2);
        req = 2'b00; addr = '0;
        tick(); tick();
        check("ra_done", done, 2'b01);
        check("ra_rdata", rdata, 32'h2222_2222);
        tick();

`ifdef APB_ARB_TIMEOUT_EN
        // timeout with Pready held low
        apb.Pready = 1'b0;
        req = 2'b10; wr = 2'b00; addr = {5'd5, 5'd0};
        tick();
        req = 2'b00; addr = '0;
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("to%0d_wait", i), {done, busy}, 3'b001);
        end
        tick();
        check("to_done", done, 2'b10);
        check("to_err", err, 1);
        check("to_rdata", rdata, 0);
        check("to_busy", busy, 0);
        check("to_pselx", {apb.Pselx, apb.Penable}, 2'b00);
        apb.Pready = 1'b1;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
